// File: rtl/mem_wb_pkg.sv
// Shared pipeline-register definitions: write-back select encoding, payload layout
// and the skid-controller state type used by the MEM/WB stage and its siblings.
package mem_wb_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam int unsigned MEM_WB_N          = 32;
    localparam int unsigned MEM_WB_REG_ADDR_W = 5;

    // Payload at the default datapath widths; parametrised stages mirror this layout.
    typedef struct packed {
        logic [MEM_WB_N-1:0]          pc_plus4;
        logic [MEM_WB_N-1:0]          read_data;
        logic [MEM_WB_N-1:0]          alu_result;
        logic [MEM_WB_REG_ADDR_W-1:0] write_reg;
        logic [1:0]                   mem_to_reg;
        logic                         reg_write;
    } mem_wb_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mem_wb_skid_ctrl.sv
// Occupancy controller for the two-entry MEM/WB skid buffer; all updates on the falling edge.
//
//  state    | meaning
//  ---------+--------------------------------------------------
//  ST_EMPTY | no entry held, outputs invalid
//  ST_ONE   | main entry valid, skid free
//  ST_TWO   | main and skid both valid, upstream stalled
module mem_wb_skid_ctrl
    import mem_wb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load_main,
    output logic load_skid,
    output logic main_from_skid
);

    skid_state_t state, state_nxt;
    logic        in_fire, out_fire;

    // in_ready is a pure function of state and reset so out_ready never reaches upstream.
    assign in_ready  = reset && (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (in_fire) state_nxt = ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire)      state_nxt = ST_TWO;
                    else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (out_fire) state_nxt = ST_ONE;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush) begin
            case (state)
                ST_EMPTY: load_main = in_fire;
                ST_ONE: begin
                    load_main = in_fire && out_fire;
                    load_skid = in_fire && !out_fire;
                end
                ST_TWO:   main_from_skid = out_fire;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM/WB pipeline register with valid/ready handshake, two-entry skid buffer and flush.
// Optional MEM_WB_FWD_EN adds the MEM/WB forwarding outputs (fwd_valid/fwd_reg/fwd_data).
module mem_wb_pipe_stage
    import mem_wb_pkg::*;
#(
    parameter int unsigned     N           = 32,
    parameter int unsigned     REG_ADDR_W  = 5,
    parameter logic [N-1:0]    RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_pc_plus4,
    input  logic [N-1:0]          in_read_data,
    input  logic [N-1:0]          in_alu_result,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    input  logic [1:0]            in_mem_to_reg,
    input  logic                  in_reg_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_pc_plus4,
    output logic [N-1:0]          out_read_data,
    output logic [N-1:0]          out_alu_result,
    output logic [REG_ADDR_W-1:0] out_write_reg,
    output logic [1:0]            out_mem_to_reg,
`ifdef MEM_WB_FWD_EN
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [N-1:0]          fwd_data,
`endif
    output logic                  out_reg_write
);

    typedef struct packed {
        logic [N-1:0]          pc_plus4;
        logic [N-1:0]          read_data;
        logic [N-1:0]          alu_result;
        logic [REG_ADDR_W-1:0] write_reg;
        logic [1:0]            mem_to_reg;
        logic                  reg_write;
    } payload_t;

    localparam payload_t PAYLOAD_RST = '{
        pc_plus4:   RESET_VALUE,
        read_data:  RESET_VALUE,
        alu_result: RESET_VALUE,
        write_reg:  '0,
        mem_to_reg: WB_SEL_ALU,
        reg_write:  1'b0
    };

    payload_t main_q, skid_q, in_payload;
    logic     load_main, load_skid, main_from_skid;

    assign in_payload = '{
        pc_plus4:   in_pc_plus4,
        read_data:  in_read_data,
        alu_result: in_alu_result,
        write_reg:  in_write_reg,
        mem_to_reg: in_mem_to_reg,
        reg_write:  in_reg_write
    };

    mem_wb_skid_ctrl u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .load_main      (load_main),
        .load_skid      (load_skid),
        .main_from_skid (main_from_skid)
    );

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= PAYLOAD_RST;
            skid_q <= PAYLOAD_RST;
        end else if (flush) begin
            main_q <= PAYLOAD_RST;
            skid_q <= PAYLOAD_RST;
        end else begin
            if (main_from_skid)
                main_q <= skid_q;
            else if (load_main)
                main_q <= in_payload;
            if (load_skid)
                skid_q <= in_payload;
        end
    end

    assign out_pc_plus4   = main_q.pc_plus4;
    assign out_read_data  = main_q.read_data;
    assign out_alu_result = main_q.alu_result;
    assign out_write_reg  = main_q.write_reg;
    assign out_mem_to_reg = main_q.mem_to_reg;
    // Bubbles and x0 destinations must never reach the register-file write port.
    assign out_reg_write  = main_q.reg_write && out_valid && (main_q.write_reg != '0);

`ifdef MEM_WB_FWD_EN
    assign fwd_valid = out_reg_write;
    assign fwd_reg   = main_q.write_reg;

    always_comb begin
        case (main_q.mem_to_reg)
            WB_SEL_MEM: fwd_data = main_q.read_data;
            WB_SEL_PC4: fwd_data = main_q.pc_plus4;
            default:    fwd_data = main_q.alu_result;
        endcase
    end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: a FIFO-of-depth-two reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_wb_pipe_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc_plus4, in_read_data, in_alu_result;
    logic [4:0]  in_write_reg;
    logic [1:0]  in_mem_to_reg;
    logic        in_reg_write;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc_plus4, out_read_data, out_alu_result;
    logic [4:0]  out_write_reg;
    logic [1:0]  out_mem_to_reg;
    logic        out_reg_write;
`ifdef MEM_WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif

    mem_wb_pipe_stage dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc_plus4    (in_pc_plus4),
        .in_read_data   (in_read_data),
        .in_alu_result  (in_alu_result),
        .in_write_reg   (in_write_reg),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_reg_write   (in_reg_write),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc_plus4   (out_pc_plus4),
        .out_read_data  (out_read_data),
        .out_alu_result (out_alu_result),
        .out_write_reg  (out_write_reg),
        .out_mem_to_reg (out_mem_to_reg),
`ifdef MEM_WB_FWD_EN
        .fwd_valid      (fwd_valid),
        .fwd_reg        (fwd_reg),
        .fwd_data       (fwd_data),
`endif
        .out_reg_write  (out_reg_write)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [1:0]  m2r;
        logic        rw;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 0;

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the stage is a 2-deep FIFO; flush and reset empty it.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
        end else begin
            automatic bit inf  = in_valid && (q.size() < 2);
            automatic bit outf = (q.size() > 0) && out_ready;
            automatic ent_t e;
            e.pc = in_pc_plus4; e.rd = in_read_data; e.alu = in_alu_result;
            e.wr = in_write_reg; e.m2r = in_mem_to_reg; e.rw = in_reg_write;
            if (flush) begin
                q.delete();
            end else begin
                if (outf) void'(q.pop_front());
                if (inf)  q.push_back(e);
            end
        end
    end

    initial begin
        while (!done) begin
            @(posedge clk);
            #2;
            if (done) break;
            chk("in_ready", {63'd0, in_ready}, {63'd0, (reset === 1'b1) && (q.size() < 2)});
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            if (q.size() > 0) begin
                automatic ent_t h = q[0];
                chk("out_pc_plus4", {32'd0, out_pc_plus4}, {32'd0, h.pc});
                chk("out_read_data", {32'd0, out_read_data}, {32'd0, h.rd});
                chk("out_alu_result", {32'd0, out_alu_result}, {32'd0, h.alu});
                chk("out_write_reg", {59'd0, out_write_reg}, {59'd0, h.wr});
                chk("out_mem_to_reg", {62'd0, out_mem_to_reg}, {62'd0, h.m2r});
                chk("out_reg_write", {63'd0, out_reg_write}, {63'd0, h.rw && (h.wr != 0)});
`ifdef MEM_WB_FWD_EN
                chk("fwd_data", {32'd0, fwd_data},
                    {32'd0, (h.m2r == 2'b01) ? h.rd : (h.m2r == 2'b10) ? h.pc : h.alu});
                chk("fwd_reg", {59'd0, fwd_reg}, {59'd0, h.wr});
                chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, h.rw && (h.wr != 0)});
`endif
            end else begin
                chk("out_reg_write_idle", {63'd0, out_reg_write}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic put(input logic v, input logic [31:0] alu);
        in_valid      = v;
        in_alu_result = alu;
        in_pc_plus4   = alu + 32'h100;
        in_read_data  = ~alu;
        in_write_reg  = 5'd1;
        in_mem_to_reg = 2'b00;
        in_reg_write  = 1'b1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        put(1'b0, 32'h0);
        repeat (3) tick();
        settle();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_alu", {32'd0, out_alu_result}, 64'd0);

        tick(); reset = 1'b1; settle();
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Streaming
        tick(); out_ready = 1'b1; put(1'b1, 32'h10); settle();
        tick(); put(1'b1, 32'h20); settle();
        chk("stream_0", {32'd0, out_alu_result}, 64'h10);
        tick(); put(1'b1, 32'h30); settle();
        chk("stream_1", {32'd0, out_alu_result}, 64'h20);
        chk("stream_rdy", {63'd0, in_ready}, 64'd1);
        tick(); put(1'b0, 32'h0); settle();
        chk("stream_2", {32'd0, out_alu_result}, 64'h30);
        tick(); settle();
        chk("stream_end_valid", {63'd0, out_valid}, 64'd0);

        // Back-pressure
        tick(); out_ready = 1'b0; put(1'b1, 32'hA); settle();
        tick(); put(1'b1, 32'hB); settle();
        tick(); put(1'b0, 32'h0); settle();
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_hold", {32'd0, out_alu_result}, 64'hA);
        tick(); out_ready = 1'b1; settle();
        chk("bp_head_a", {32'd0, out_alu_result}, 64'hA);
        tick(); settle();
        chk("bp_head_b", {32'd0, out_alu_result}, 64'hB);
        chk("bp_rdy_back", {63'd0, in_ready}, 64'd1);
        tick(); settle();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Flush in TWO with a pending input
        tick(); out_ready = 1'b0; put(1'b1, 32'h1); settle();
        tick(); put(1'b1, 32'h2); settle();
        tick(); put(1'b1, 32'hC); flush = 1'b1; settle();
        tick(); flush = 1'b0; put(1'b0, 32'h0); out_ready = 1'b1; settle();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_alu", {32'd0, out_alu_result}, 64'd0);
        tick(); settle();
        chk("flush_no_c", {63'd0, out_valid}, 64'd0);

        // Flush in ONE discards a simultaneous in_fire
        tick(); put(1'b1, 32'h7); out_ready = 1'b0; settle();
        tick(); put(1'b1, 32'hC); flush = 1'b1; settle();
        tick(); flush = 1'b0; put(1'b0, 32'h0); settle();
        chk("flush1_valid", {63'd0, out_valid}, 64'd0);

        // x0 and bubble gating
        tick(); out_ready = 1'b1; put(1'b1, 32'h5); in_write_reg = 5'd0; settle();
        tick(); put(1'b0, 32'h0); settle();
        chk("x0_valid", {63'd0, out_valid}, 64'd1);
        chk("x0_gate", {63'd0, out_reg_write}, 64'd0);
        tick(); put(1'b1, 32'h6); in_write_reg = 5'd5; settle();
        tick(); put(1'b0, 32'h0); settle();
        chk("r5_write", {63'd0, out_reg_write}, 64'd1);
        tick(); settle();
        chk("bubble_gate", {63'd0, out_reg_write}, 64'd0);

`ifdef MEM_WB_FWD_EN
        tick(); put(1'b1, 32'h9); in_mem_to_reg = 2'b10; in_pc_plus4 = 32'h104; settle();
        tick(); put(1'b1, 32'h9); in_mem_to_reg = 2'b01; in_read_data = 32'hDEAD; settle();
        chk("fwd_pc4", {32'd0, fwd_data}, 64'h104);
        tick(); put(1'b0, 32'h0); settle();
        chk("fwd_mem", {32'd0, fwd_data}, 64'hDEAD);
`endif

        // Reset mid-stream while in TWO
        tick(); out_ready = 1'b0; put(1'b1, 32'h11); settle();
        tick(); put(1'b1, 32'h22); settle();
        tick(); put(1'b0, 32'h0); settle();
        chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
        tick(); reset = 1'b0; settle();
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_alu", {32'd0, out_alu_result}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        tick(); reset = 1'b1; settle();
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            tick();
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 31) == 0);
            in_pc_plus4   = $urandom;
            in_read_data  = $urandom;
            in_alu_result = $urandom;
            in_write_reg  = 5'($urandom_range(0, 31));
            in_mem_to_reg = 2'($urandom_range(0, 3));
            in_reg_write  = 1'($urandom_range(0, 1));
        end

        tick(); in_valid = 1'b0; flush = 1'b0; settle();
        done = 1'b1;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
